// File: rtl/tick_rr_arbiter.sv
// Per-source price FIFOs feeding a round-robin arbiter and a valid/ready output register.
// Define TICK_ARB_STRICT_PRIO_EN to make the lowest-index non-empty source always win.
module tick_rr_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC*DATA_W-1:0]    s_price,
    input  logic [N_SRC-1:0]           s_valid,
    output logic [DATA_W-1:0]          m_price,
    output logic [$clog2(N_SRC)-1:0]   m_src,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [N_SRC*CNT_W-1:0]     drop_cnt,
    output logic [N_SRC-1:0]           overflow
);

    localparam int SRC_W = $clog2(N_SRC);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [N_SRC][DEPTH];
    logic [DATA_W-1:0] head [N_SRC];
    logic [PTR_W-1:0]  wr_ptr [N_SRC];
    logic [PTR_W-1:0]  rd_ptr [N_SRC];
    logic [OCC_W-1:0]  occ [N_SRC];
    logic [CNT_W-1:0]  drops [N_SRC];

    logic [N_SRC-1:0]  not_empty, full, push, pop;
    logic [SRC_W-1:0]  grant_idx;
    logic              any_ne;
    logic              load_en;

    assign any_ne  = |not_empty;
    assign load_en = !m_valid || m_ready;

    // A pulse may enter a full FIFO only when the same cycle's pop makes room.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            not_empty[i] = (occ[i] != '0);
            full[i]      = (occ[i] == OCC_W'(DEPTH));
            pop[i]       = load_en && any_ne && (grant_idx == SRC_W'(i));
            push[i]      = s_valid[i] && (!full[i] || pop[i]);
            head[i]      = mem[i][rd_ptr[i]];
        end
    end

    // NOTE: storage carries no reset; occupancy alone defines which entries are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= s_price[i*DATA_W +: DATA_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                occ[i]    <= '0;
                drops[i]  <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   occ[i] <= occ[i] + OCC_W'(1);
                    2'b01:   occ[i] <= occ[i] - OCC_W'(1);
                    default: occ[i] <= occ[i];
                endcase
                if (s_valid[i] && !push[i]) begin
                    overflow[i] <= 1'b1;
                    if (drops[i] != '1) drops[i] <= drops[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < N_SRC; i++) drop_cnt[i*CNT_W +: CNT_W] = drops[i];
    end

`ifdef TICK_ARB_STRICT_PRIO_EN
    // Descending scan so the lowest-index hit is the final assignment.
    always_comb begin
        grant_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (not_empty[SRC_W'(i)]) grant_idx = SRC_W'(i);
        end
    end
`else
    logic [SRC_W-1:0] last_grant;
    logic             found;

    // Scan starts one past the previous winner, wrapping modulo N_SRC.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 1; off <= N_SRC; off++) begin
            automatic int cand = int'(last_grant) + off;
            if (cand >= N_SRC) cand = cand - N_SRC;
            if (!found && not_empty[SRC_W'(cand)]) begin
                grant_idx = SRC_W'(cand);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                last_grant <= SRC_W'(N_SRC - 1);
        else if (load_en && any_ne) last_grant <= grant_idx;
    end
`endif

    // Price and source hold their last values when the output empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_price <= '0;
            m_src   <= '0;
        end else if (load_en && any_ne) begin
            m_price <= head[grant_idx];
            m_src   <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: defaulting state_d first keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_ne) state_d = HOLD;
            HOLD:    if (m_ready && !any_ne) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_valid = (state_q == HOLD);
    end

endmodule

// File: tb/tb_tick_rr_arbiter.sv
// Scenario bench for tick_rr_arbiter: expected beats are queued with the stimulus and
// compared against the beats the output port actually delivers.
module tb_tick_rr_arbiter;

    localparam int N_SRC  = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 16;
    localparam int SRC_W  = 2;

    typedef logic [SRC_W+DATA_W-1:0] beat_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_SRC*DATA_W-1:0] s_price;
    logic [N_SRC-1:0]        s_valid;
    logic [DATA_W-1:0]       m_price;
    logic [SRC_W-1:0]        m_src;
    logic                    m_valid;
    logic                    m_ready;
    logic [N_SRC*CNT_W-1:0]  drop_cnt;
    logic [N_SRC-1:0]        overflow;

    int checks = 0;
    int errors = 0;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    obs_cyc[$];

    tick_rr_arbiter #(
        .N_SRC (N_SRC),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_price (s_price),
        .s_valid (s_valid),
        .m_price (m_price),
        .m_src   (m_src),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .drop_cnt(drop_cnt),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic set_price(input int src, input logic [DATA_W-1:0] p);
        s_price[src*DATA_W +: DATA_W] = p;
    endtask

    task automatic push_exp(input int src, input logic [DATA_W-1:0] p);
        exp_q.push_back({SRC_W'(src), p});
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = '0;
        s_price = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    // Records every beat that will handshake on the coming edge; inputs are already set.
    task automatic collect(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (m_valid && m_ready) begin
                obs_q.push_back({m_src, m_price});
                obs_cyc.push_back(c);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = '1;
        s_price = '1;
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++;
        if (m_price !== '0) begin errors++; $display("FAIL reset_m_price: got %h want 00", m_price); end
        checks++;
        if (m_src !== '0) begin errors++; $display("FAIL reset_m_src: got %0d want 0", m_src); end
        checks++;
        if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt: got %h want 0", drop_cnt); end
        checks++;
        if (overflow !== '0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        do_reset();
    endtask

    task automatic test_single();
        beat_t e, o;
        do_reset();
        m_ready = 1'b1;
        set_price(2, 8'h37);
        s_valid = 4'b0100;
        push_exp(2, 8'h37);
        @(negedge clk);
        s_valid = '0;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: m_valid got %b want 0", m_valid); end
        collect(4);
        checks++;
        if (obs_cyc.size() != 1 || obs_cyc[0] != 1) begin
            errors++;
            $display("FAIL single_latency: beats %0d first at %0d, want 1 beat at 1", obs_cyc.size(),
                     (obs_cyc.size() > 0) ? obs_cyc[0] : -1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL single_beat: missing beat, want src %0d price %h", e[9:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL single_beat: got src %0d price %h want src %0d price %h", o[9:8], o[7:0], e[9:8], e[7:0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra: %0d extra beats, want 0", obs_q.size()); end
    endtask

    task automatic test_contention();
        beat_t e, o;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < N_SRC; i++) begin
            set_price(i, DATA_W'(8'h10 + i));
            push_exp(i, DATA_W'(8'h10 + i));
        end
        s_valid = 4'b1111;
        @(negedge clk);
        s_valid = '0;
        collect(8);
        checks++;
        if (obs_cyc.size() != 4 || obs_cyc[3] - obs_cyc[0] != 3) begin
            errors++; $display("FAIL contention_b2b: %0d beats, want 4 consecutive", obs_cyc.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL contention_beat: missing beat, want src %0d price %h", e[9:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL contention_beat: got src %0d price %h want src %0d price %h", o[9:8], o[7:0], e[9:8], e[7:0]);
                end
            end
        end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL contention_idle: m_valid got %b want 0", m_valid); end
    endtask

    task automatic test_fairness();
        beat_t e, o;
        int    waited;
        do_reset();
        m_ready = 1'b1;
        set_price(0, 8'hA0);
        set_price(3, 8'hA3);
        for (int k = 0; k < 8; k++) begin
`ifdef TICK_ARB_STRICT_PRIO_EN
            push_exp(0, 8'hA0);
`else
            if (k % 2 == 0) push_exp(0, 8'hA0);
            else            push_exp(3, 8'hA3);
`endif
        end
        s_valid = 4'b1001;
        collect(12);
        s_valid = '0;
        waited = 0;
        while (m_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL fairness_drain: m_valid got %b want 0 within 20 cycles", m_valid); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL fairness_beat: missing beat, want src %0d price %h", e[9:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL fairness_beat: got src %0d price %h want src %0d price %h", o[9:8], o[7:0], e[9:8], e[7:0]);
                end
            end
        end
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_backpressure();
        beat_t e, o;
        do_reset();
        set_price(1, 8'h21);
        set_price(2, 8'h22);
        s_valid = 4'b0110;
        @(negedge clk);
        set_price(0, 8'h20);
        s_valid = 4'b0001;
        @(negedge clk);
        s_valid = '0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_price !== 8'h21) begin
                errors++; $display("FAIL bp_price_stable[%0d]: valid %b price %h want 1 21", k, m_valid, m_price);
            end
            checks++;
            if (m_src !== 2'd1) begin errors++; $display("FAIL bp_src_stable[%0d]: got %0d want 1", k, m_src); end
            @(negedge clk);
        end
        push_exp(1, 8'h21);
`ifdef TICK_ARB_STRICT_PRIO_EN
        push_exp(0, 8'h20);
        push_exp(2, 8'h22);
`else
        push_exp(2, 8'h22);
        push_exp(0, 8'h20);
`endif
        m_ready = 1'b1;
        collect(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL bp_beat: missing beat, want src %0d price %h", e[9:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL bp_beat: got src %0d price %h want src %0d price %h", o[9:8], o[7:0], e[9:8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        beat_t                  e, o;
        logic [N_SRC*CNT_W-1:0] want_cnt;
        do_reset();
        want_cnt = '0;
        want_cnt[1*CNT_W +: CNT_W] = CNT_W'(1);
        s_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            set_price(1, DATA_W'(8'h31 + k));
            @(negedge clk);
        end
        s_valid = '0;
        checks++;
        if (drop_cnt !== want_cnt) begin errors++; $display("FAIL ovf_drop_cnt: got %h want %h", drop_cnt, want_cnt); end
        checks++;
        if (overflow !== 4'b0010) begin errors++; $display("FAIL ovf_flag: got %b want 0010", overflow); end
        push_exp(1, 8'h31);
        push_exp(1, 8'h32);
        push_exp(1, 8'h33);
        m_ready = 1'b1;
        collect(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL ovf_beat: missing beat, want src %0d price %h", e[9:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL ovf_beat: got src %0d price %h want src %0d price %h", o[9:8], o[7:0], e[9:8], e[7:0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL ovf_extra: %0d extra beats, want 0", obs_q.size()); end
        checks++;
        if (overflow !== 4'b0010 || drop_cnt !== want_cnt) begin
            errors++; $display("FAIL ovf_sticky: flag %b cnt %h want 0010 %h", overflow, drop_cnt, want_cnt);
        end
    endtask

    task automatic test_reset_mid();
        beat_t e, o;
        do_reset();
        set_price(1, 8'h41);
        set_price(2, 8'h42);
        set_price(3, 8'h43);
        s_valid = 4'b1110;
        @(negedge clk);
        s_valid = '0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: m_valid got %b want 1", m_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_price !== '0) begin
            errors++; $display("FAIL rstmid_async: valid %b price %h want 0 00", m_valid, m_price);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        set_price(0, 8'h50);
        set_price(3, 8'h53);
        s_valid = 4'b1001;
        push_exp(0, 8'h50);
        push_exp(3, 8'h53);
        @(negedge clk);
        s_valid = '0;
        collect(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL rstmid_beat: missing beat, want src %0d price %h", e[9:8], e[7:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL rstmid_beat: got src %0d price %h want src %0d price %h", o[9:8], o[7:0], e[9:8], e[7:0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_stale: %0d extra beats, want 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_rr_arbiter.md
Name: tick_rr_arbiter

Overview:
Shares the single NPU price input between N_SRC symbol-filter parser instances. Each parser emits one-cycle price pulses with no backpressure. This block buffers the pulses per source, arbitrates round-robin, and presents one AXI-Stream-style output (valid/ready) tagged with the source index. It sits between the parser bank and the NPU; per-source drop counters report overruns.

Parameters:
N_SRC, 4, number of parser sources (2..8)
DATA_W, 8, price width per source
DEPTH, 2, per-source FIFO depth (power of 2, >=2)
CNT_W, 16, per-source drop counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_price  in  N_SRC*DATA_W  source i price in bits [i*DATA_W +: DATA_W]
s_valid  in  N_SRC  one-cycle price pulse per source; no ready is returned
m_price  out  DATA_W  granted price
m_src  out  $clog2(N_SRC)  index of the granted source
m_valid  out  1  output valid
m_ready  in  1  NPU accepts when m_valid && m_ready
drop_cnt  out  N_SRC*CNT_W  per-source dropped-pulse counters, saturating
overflow  out  N_SRC  sticky per-source drop flag

Behaviour:
- Reset (async, rst_n low):
  - All FIFOs empty.
  - m_valid=0, m_price=0, m_src=0.
  - drop_cnt=0, overflow=0.
  - Round-robin pointer last_grant=N_SRC-1, so source 0 has first priority.
- Per-source FIFO i:
  - Push on s_valid[i] when not full, or when full and popped in the same cycle.
  - Otherwise the pulse is dropped: drop_cnt[i] increments, saturating at all-ones, and overflow[i] is set. Both clear only on reset.
- Output register load condition: load_en = !m_valid || m_ready.
- Arbitration, evaluated when load_en is true:
  - Search non-empty FIFOs starting at last_grant+1, wrapping modulo N_SRC.
  - The first hit k is popped, and the output loads m_price=head_k, m_src=k, m_valid=1. last_grant becomes k.
  - If no FIFO is non-empty and load_en is true: m_valid becomes 0. m_price and m_src hold their last values.
- Output state machine, two states:
  - IDLE (m_valid=0): moves to HOLD when any FIFO is non-empty at the edge.
  - HOLD (m_valid=1):
    - Handshake and a FIFO non-empty: reload and stay in HOLD (back-to-back, 1 beat per cycle).
    - Handshake and all FIFOs empty: go to IDLE.
    - No handshake: m_price and m_src are stable; no pop; last_grant is unchanged.
- Latency: a pulse at edge E0 is written to the FIFO. If the output is free and no other source is ahead, m_valid rises after edge E1. Minimum latency is 2 edges; there is no bypass path.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle are both honoured; occupancy is unchanged.
  - Several sources pulsing in one cycle all enqueue in that cycle, then drain in round-robin order.
- Occupancy counter is $clog2(DEPTH)+1 bits. Read and write pointers wrap modulo DEPTH.
- s_valid is ignored while rst_n is low. A reset mid-transfer discards all queued data and drops m_valid asynchronously.

Optional Feature:
Macro TICK_ARB_STRICT_PRIO_EN.
- Defined: fixed priority, where the lowest-index non-empty source always wins. last_grant is not maintained. All other behaviour is identical.
- Undefined: round-robin as specified above.

Test Plan:
- Single source: s_valid[2] pulse with s_price=0x37, m_ready=1. Required: m_valid=1, m_price=0x37, m_src=2, exactly 2 edges after the pulse, for one cycle.
- Contention: all 4 sources pulse in one cycle (0x10,0x11,0x12,0x13), m_ready=1. Required: four back-to-back beats with m_src 0,1,2,3 and matching prices, then m_valid=0.
- Backpressure: m_ready=0 for 5 cycles while m_valid=1. Required: m_price and m_src are stable; the next grant follows last_grant+1.
- Overflow: m_ready=0; source 1 pulses 4 times (DEPTH=2, 1 entry already in the output register). Required: drop_cnt[1]=1, overflow[1]=1, and the remaining values are delivered in order once m_ready=1.
- Fairness: sources 0 and 3 pulse continuously, m_ready=1. Required: m_src alternates 0,3,0,3.
- Reset mid-operation: assert rst_n low with 3 entries queued and m_valid=1. Required: m_valid=0 immediately; after release the first grant goes to source 0. With TICK_ARB_STRICT_PRIO_EN defined and sources 0 and 3 continuous, only m_src=0 is granted.
